// File: rtl/norm_shift29_if.sv
// Upstream sum/exponent channel and downstream normalized-result channel for norm_shift29.
interface norm_shift29_if;
  logic        in_valid;
  logic        in_ready;
  logic [28:0] in_sum;
  logic [4:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] out_mant;
  logic [4:0]  out_exp;
  logic [4:0]  out_shamt;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;

  modport master (
    output in_valid, in_sum, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_shamt,
           out_zero, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_sum, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_shamt,
           out_zero, out_ovf, out_unf
  );
endinterface

// File: rtl/norm_shift29.sv
// Post-adder normalizer: handles carry/zero/normal inputs in one cycle and
// left-shifts one bit per cycle until the leading one reaches bit 27 or exp hits 0.
module norm_shift29 (
  input  logic             clk,
  input  logic             rstn,
  norm_shift29_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [27:0] mant_q, mant_d;
  logic [4:0]  exp_q, exp_d;
  logic [4:0]  shamt_q, shamt_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      shamt_q <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      shamt_q <= shamt_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    shamt_d = shamt_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          shamt_d = '0;
          state_d = DONE;
          if (bus.in_sum == '0) begin
            mant_d = '0;
            exp_d  = '0;
            zero_d = 1'b1;
          end else if (bus.in_sum[28]) begin
            if (bus.in_exp == 5'd31) begin
              mant_d = '1;
              exp_d  = 5'd31;
              ovf_d  = 1'b1;
            end else begin
              mant_d = bus.in_sum[28:1];
              exp_d  = bus.in_exp + 5'd1;
            end
          end else begin
            mant_d = bus.in_sum[27:0];
            exp_d  = bus.in_exp;
            if (!bus.in_sum[27]) begin
              if (bus.in_exp == '0) unf_d = 1'b1;
              else                  state_d = SHIFT;
            end
          end
        end
      end

      SHIFT: begin
        mant_d  = {mant_q[26:0], 1'b0};
        exp_d   = (exp_q != '0) ? exp_q - 5'd1 : '0;
        shamt_d = shamt_q + 5'd1;
        // Exit is decided on the post-shift values: mant_q[26] becomes the new
        // leading bit, and exp_q==1 means the new exponent is 0.
        if (mant_q[26] || exp_q <= 5'd1) begin
          state_d = DONE;
          unf_d   = ~mant_q[26];
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_mant  = mant_q;
  assign bus.out_exp   = exp_q;
  assign bus.out_shamt = shamt_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_unf   = unf_q;

endmodule

// File: tb/tb_norm_shift29.sv
// Self-checking bench for norm_shift29: directed corner cases plus randomized
// transactions compared against a leading-zero-count reference model.
module tb_norm_shift29;

  logic clk;
  logic rstn;
  int   pass_cnt;
  int   total_cnt;

  norm_shift29_if bus ();

  norm_shift29 dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result packed as {mant, exp, shamt, zero, ovf, unf}.
  logic [40:0] got;
  assign got = {bus.out_mant, bus.out_exp, bus.out_shamt,
                bus.out_zero, bus.out_ovf, bus.out_unf};

  function automatic logic [40:0] model(input logic [28:0] s, input logic [4:0] e,
                                        output int lat);
    logic [27:0] m;
    int lz;
    int k;
    lat = 1;
    if (s == 0) return {28'd0, 5'd0, 5'd0, 3'b100};
    if (s[28]) begin
      if (e == 5'd31) return {28'hFFFFFFF, 5'd31, 5'd0, 3'b010};
      m = s[28:1];
      return {m, 5'(e + 5'd1), 5'd0, 3'b000};
    end
    lz = 0;
    for (int i = 27; i >= 0; i--) begin
      if (s[i]) break;
      lz++;
    end
    k = (lz < int'(e)) ? lz : int'(e);
    m = s[27:0] << k;
    lat = 1 + k;
    return {m, 5'(int'(e) - k), 5'(k), 1'b0, 1'b0, (lz > int'(e))};
  endfunction

  task automatic do_txn(input logic [28:0] s, input logic [4:0] e,
                        input logic [40:0] exp_res, input int exp_lat,
                        input int hold, input string name);
    int lat;
    @(negedge clk);
    total_cnt++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL %s in_ready_before_capture got=%b want=1", name, bus.in_ready);
    else pass_cnt++;
    bus.in_valid = 1'b1;
    bus.in_sum   = s;
    bus.in_exp   = e;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      lat++;
      @(negedge clk);
    end while (bus.out_valid !== 1'b1 && lat < 40);
    total_cnt++;
    if (bus.out_valid !== 1'b1 || lat != exp_lat)
      $display("FAIL %s latency got=%0d (valid=%b) want=%0d", name, lat, bus.out_valid, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if (got !== exp_res)
      $display("FAIL %s result got mant=%h exp=%0d sh=%0d z/o/u=%b want mant=%h exp=%0d sh=%0d z/o/u=%b",
               name, got[40:13], got[12:8], got[7:3], got[2:0],
               exp_res[40:13], exp_res[12:8], exp_res[7:3], exp_res[2:0]);
    else pass_cnt++;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      total_cnt++;
      if (got !== exp_res || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        $display("FAIL %s hold%0d got=%h valid=%b ready=%b want=%h valid=1 ready=0",
                 name, c, got, bus.out_valid, bus.in_ready, exp_res);
      else pass_cnt++;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL %s release got ready=%b valid=%b want ready=1 valid=0",
               name, bus.in_ready, bus.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || got !== 41'd0)
      $display("FAIL reset_state got ready=%b valid=%b res=%h want ready=1 valid=0 res=0",
               bus.in_ready, bus.out_valid, got);
    else pass_cnt++;
    @(posedge clk);
    #4 rstn = 1'b1;
  endtask

  task automatic test_directed();
    do_txn(29'h0000001, 5'd30, {28'h8000000, 5'd3, 5'd27, 3'b000}, 28, 0, "full_shift");
    do_txn(29'h0000100, 5'd5,  {28'h0002000, 5'd0, 5'd5,  3'b001}, 6,  0, "underflow");
    do_txn(29'h10000001, 5'd10, {28'h8000000, 5'd11, 5'd0, 3'b000}, 1, 0, "carry");
    do_txn(29'h18000000, 5'd31, {28'hFFFFFFF, 5'd31, 5'd0, 3'b010}, 1, 0, "overflow");
    do_txn(29'h0000000, 5'd17, {28'h0, 5'd0, 5'd0, 3'b100}, 1, 0, "zero");
    do_txn(29'h0000300, 5'd0,  {28'h0000300, 5'd0, 5'd0, 3'b001}, 1, 0, "exp0_unf");
    do_txn(29'h0400000, 5'd5,  {28'h8000000, 5'd0, 5'd5, 3'b000}, 6, 0, "exact_exp0");
  endtask

  task automatic test_backpressure();
    do_txn(29'h0123456, 5'd20, {28'h91A2B00, 5'd13, 5'd7, 3'b000}, 8, 10, "backpressure");
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sum   = 29'h0000001;
    bus.in_exp   = 5'd30;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL mid_shift_busy got ready=%b valid=%b want ready=0 valid=0",
               bus.in_ready, bus.out_valid);
    else pass_cnt++;
    #2 rstn = 1'b0;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || got !== 41'd0)
      $display("FAIL mid_shift_abort got ready=%b valid=%b res=%h want ready=1 valid=0 res=0",
               bus.in_ready, bus.out_valid, got);
    else pass_cnt++;
    @(posedge clk);
    #4 rstn = 1'b1;
    do_txn(29'h08000000, 5'd4, {28'h8000000, 5'd4, 5'd0, 3'b000}, 1, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [28:0] s;
    logic [4:0]  e;
    logic [40:0] r;
    int          lat;
    for (int n = 0; n < 40; n++) begin
      e = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 4))
        0: s = '0;
        1: begin s = 29'($urandom); s[28] = 1'b1; if (n % 3 == 0) e = 5'd31; end
        2: begin s = 29'($urandom); s[28:27] = 2'b01; end
        default: begin
          s = 29'(28'($urandom) >> $urandom_range(1, 27));
          if (s == 0) s = 29'd1;
        end
      endcase
      r = model(s, e, lat);
      do_txn(s, e, r, lat, $urandom_range(0, 3), $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_back_to_back();
    logic [40:0] r;
    int          lat;
    for (int n = 0; n < 4; n++) begin
      r = model(29'h0000040 << n, 5'd9, lat);
      do_txn(29'h0000040 << n, 5'd9, r, lat, 0, $sformatf("b2b%0d", n));
    end
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/norm_shift29.md
NORM_SHIFT29 -- requirements
Module: norm_shift29

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream sum/exponent pair is valid.
REQ-005 in_ready  output  1  block can accept a new pair.
REQ-006 in_sum  input  29  unsigned adder-stage sum; bit 28 is the carry-out.
REQ-007 in_exp  input  5  unsigned exponent associated with in_sum.
REQ-008 out_valid  output  1  normalized result is valid.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_mant  output  28  normalized mantissa; bit 27 is the leading one.
REQ-011 out_exp  output  5  adjusted exponent.
REQ-012 out_shamt  output  5  number of left shifts applied; 0 for the carry, zero, and already-normal cases.
REQ-013 out_zero, out_ovf, out_unf  output  1 each  zero, overflow, and underflow flags.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT, and DONE. in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 An input transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge; the pair is captured into internal mant/exp registers on that edge.
REQ-016 Capture with in_sum==0 SHALL load mant=0, exp=0, zero=1 and go to DONE.
REQ-017 Capture with in_sum[28]==1 and in_exp<31 SHALL load mant=in_sum[28:1] (LSB dropped, no rounding) and exp=in_exp+1, then go to DONE.
REQ-018 Capture with in_sum[28]==1 and in_exp==31 SHALL load mant=28'hFFFFFFF, exp=31, ovf=1 (saturate), then go to DONE.
REQ-019 Capture with in_sum[28:27]==2'b01 SHALL load mant=in_sum[27:0] and exp=in_exp, then go to DONE.
REQ-020 Capture with in_sum[28:27]==2'b00 and in_sum!=0 SHALL go to DONE with unf=1 and mant unshifted if in_exp==0; otherwise it SHALL go to SHIFT.
REQ-021 Each cycle in SHIFT SHALL apply mant<<=1, exp-=1, and shamt+=1. The FSM SHALL go to DONE on the edge where the new mant[27]==1 or the new exp==0.
REQ-022 If SHIFT exits because exp==0 while mant[27]==0, unf SHALL be set to 1.
REQ-023 Latency, measured from the capture edge to the first cycle with out_valid high: 1 cycle for the zero, carry, already-normal, and in_exp==0 cases; 1+k cycles when k left shifts are needed (maximum 28).
REQ-024 out_mant, out_exp, out_shamt, and the flags SHALL be driven from registers. They SHALL hold stable while out_valid==1 and out_ready==0 (backpressure of any length).
REQ-025 When out_valid and out_ready are both 1 on an edge, the FSM SHALL return to IDLE. Flags and shamt SHALL clear on the next capture.
REQ-026 No input SHALL be accepted in SHIFT or DONE; there is no bypass of an input into DONE on the same cycle.
REQ-027 The exp decrement SHALL never wrap below 0. The exp increment SHALL never wrap above 31.

Reset
REQ-028 While rstn==0, the FSM SHALL be in IDLE with out_valid=0, in_ready=1, out_mant=0, out_exp=0, out_shamt=0, out_zero=0, out_ovf=0, out_unf=0.
REQ-029 Assertion of rstn during SHIFT or DONE SHALL abort the operation immediately without waiting for a clock edge. The pending result SHALL be discarded.
REQ-030 After rstn deasserts, the first rising edge SHALL be able to capture a new input.

Verification
REQ-031 The bench SHALL cover a full left shift: sum=29'h0000001, exp=30 -> out_mant=28'h8000000, out_exp=3, shamt=27, out_valid on cycle 28 after capture, all flags 0.
REQ-032 The bench SHALL cover underflow: sum=29'h0000100, exp=5 -> out_mant=28'h0002000, out_exp=0, shamt=5, unf=1, out_valid on cycle 6.
REQ-033 The bench SHALL cover carry and overflow:
  - sum=29'h10000001, exp=10 -> out_mant=28'h8000000, out_exp=11, out_valid on cycle 1.
  - sum=29'h18000000, exp=31 -> out_mant=28'hFFFFFFF, out_exp=31, ovf=1.
REQ-034 The bench SHALL cover a zero input: sum=0, exp=17 -> out_mant=0, out_exp=0, zero=1, out_valid on cycle 1.
REQ-035 The bench SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> outputs unchanged, in_ready=0 throughout. Asserting out_ready SHALL give IDLE on the next cycle.
REQ-036 The bench SHALL cover reset mid-shift: rstn pulsed low during SHIFT of sum=29'h0000001 -> out_valid=0 and in_ready=1 immediately. A new input sum=29'h08000000, exp=4 is then accepted -> out_mant=28'h8000000, out_exp=4.
